// File: rtl/vga_sprite_engine.sv
// Bouncing-box sprite overlay for a VGA pixel stream. The box moves diagonally once per frame,
// bounces off the active-area edges, and the colour path adds one pix_ce cycle of latency.
module vga_sprite_engine #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_W    = 32,
  parameter int unsigned BOX_H    = 32,
  parameter int unsigned SPEED    = 2,
  parameter logic [7:0]  BOX_RGB  = 8'b111_000_11,
  parameter logic [7:0]  BG_RGB   = 8'b000_000_00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pix_ce_i,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        frame_start_i,
  input  logic        pause_i,
  output logic [2:0]  r_o,
  output logic [2:0]  g_o,
  output logic [1:0]  b_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam logic [11:0] MaxX = 12'(H_ACTIVE - BOX_W);
  localparam logic [11:0] MaxY = 12'(V_ACTIVE - BOX_H);
  localparam logic [11:0] Step = 12'(SPEED);
  localparam logic [11:0] BoxW = 12'(BOX_W);
  localparam logic [11:0] BoxH = 12'(BOX_H);

  typedef enum logic [1:0] {
    StDr = 2'd0,
    StDl = 2'd1,
    StUr = 2'd2,
    StUl = 2'd3
  } dir_e;

  dir_e        dir_q, dir_d;
  logic [10:0] x_pos_q, x_pos_d;
  logic [10:0] y_pos_q, y_pos_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        hsync_q, vsync_q;

  logic        right, down, right_n, down_n;
  logic [11:0] x_ext, y_ext, h_ext, v_ext;
  logic        in_box;

  assign x_ext = {1'b0, x_pos_q};
  assign y_ext = {1'b0, y_pos_q};
  assign h_ext = {1'b0, hcount_i};
  assign v_ext = {1'b0, vcount_i};

  // Position/direction next state; each axis bounces independently, so a corner flips both.
  always_comb begin
    right   = (dir_q == StDr) || (dir_q == StUr);
    down    = (dir_q == StDr) || (dir_q == StDl);
    right_n = right;
    down_n  = down;
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    dir_d   = dir_q;
    if (pix_ce_i && frame_start_i && !pause_i) begin
      if (right) begin
        if (x_ext + Step >= MaxX) begin
          x_pos_d = MaxX[10:0];
          right_n = 1'b0;
        end else begin
          x_pos_d = 11'(x_ext + Step);
        end
      end else if (x_ext <= Step) begin
        x_pos_d = '0;
        right_n = 1'b1;
      end else begin
        x_pos_d = 11'(x_ext - Step);
      end

      if (down) begin
        if (y_ext + Step >= MaxY) begin
          y_pos_d = MaxY[10:0];
          down_n  = 1'b0;
        end else begin
          y_pos_d = 11'(y_ext + Step);
        end
      end else if (y_ext <= Step) begin
        y_pos_d = '0;
        down_n  = 1'b1;
      end else begin
        y_pos_d = 11'(y_ext - Step);
      end

      unique case ({down_n, right_n})
        2'b11:   dir_d = StDr;
        2'b10:   dir_d = StDl;
        2'b01:   dir_d = StUr;
        default: dir_d = StUl;
      endcase
    end
  end

  // Compare against the registered position, so an update in this cycle is seen next cycle.
  always_comb begin
    in_box = (h_ext >= x_ext) && (h_ext < x_ext + BoxW) &&
             (v_ext >= y_ext) && (v_ext < y_ext + BoxH);
    rgb_d  = '0;
    if (de_i) begin
      rgb_d = in_box ? BOX_RGB : BG_RGB;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q   <= StDr;
      x_pos_q <= '0;
      y_pos_q <= '0;
      rgb_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
      if (pix_ce_i) begin
        rgb_q   <= rgb_d;
        hsync_q <= hsync_i;
        vsync_q <= vsync_i;
      end
    end
  end

  assign r_o     = rgb_q[7:5];
  assign g_o     = rgb_q[4:2];
  assign b_o     = rgb_q[1:0];
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: a default instance and a small fast-bouncing instance share stimulus;
// pixel expectations go through per-instance queues, positions are checked against a bounce model.
module tb_vga_sprite_engine;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pix_ce_i, de_i, hsync_i, vsync_i, frame_start_i, pause_i;
  logic [10:0] hcount_i, vcount_i;
  logic [2:0]  r0, g0, r1, g1;
  logic [1:0]  b0, b1;
  logic        hs0, vs0, hs1, vs1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  vga_sprite_engine dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .pix_ce_i(pix_ce_i), .hcount_i(hcount_i),
    .vcount_i(vcount_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_start_i(frame_start_i), .pause_i(pause_i), .r_o(r0), .g_o(g0), .b_o(b0),
    .hsync_o(hs0), .vsync_o(vs0)
  );

  vga_sprite_engine #(
    .H_ACTIVE(40), .V_ACTIVE(30), .BOX_W(8), .BOX_H(8), .SPEED(3),
    .BOX_RGB(8'h5a), .BG_RGB(8'h81)
  ) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .pix_ce_i(pix_ce_i), .hcount_i(hcount_i),
    .vcount_i(vcount_i), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_start_i(frame_start_i), .pause_i(pause_i), .r_o(r1), .g_o(g1), .b_o(b1),
    .hsync_o(hs1), .vsync_o(vs1)
  );

  // Model parameters per instance
  int p_max_x [2] = '{608, 32};
  int p_max_y [2] = '{448, 22};
  int p_spd   [2] = '{2, 3};
  int p_bw    [2] = '{32, 8};
  int p_bh    [2] = '{32, 8};
  logic [7:0] p_box [2] = '{8'hE3, 8'h5a};
  logic [7:0] p_bg  [2] = '{8'h00, 8'h81};

  int m_x [2];
  int m_y [2];
  bit m_r [2];
  bit m_d [2];

  logic [9:0] exp0_q [$];
  logic [9:0] exp1_q [$];
  logic [9:0] last_exp [2];

  typedef struct {
    bit         de;
    int         hc;
    int         vc;
    bit         hs;
    bit         vs;
    logic [9:0] exp;
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] act_pix(input int k);
    return (k == 0) ? {r0, g0, b0, hs0, vs0} : {r1, g1, b1, hs1, vs1};
  endfunction

  function automatic logic [31:0] act_pos(input int k);
    if (k == 0) return 32'({dut0.x_pos_q, dut0.y_pos_q, 2'(dut0.dir_q)});
    return 32'({dut1.x_pos_q, dut1.y_pos_q, 2'(dut1.dir_q)});
  endfunction

  // Direction code: DR=0, DL=1, UR=2, UL=3
  function automatic logic [31:0] exp_pos(input int k);
    return 32'({11'(m_x[k]), 11'(m_y[k]), ~m_d[k], ~m_r[k]});
  endfunction

  function automatic logic [7:0] model_rgb(input int k, input bit de, input int hc, input int vc);
    if (!de) return 8'h00;
    if (hc >= m_x[k] && hc < m_x[k] + p_bw[k] && vc >= m_y[k] && vc < m_y[k] + p_bh[k])
      return p_box[k];
    return p_bg[k];
  endfunction

  task automatic axis_step(input int pos, input bit fwd, input int mx, input int spd,
                           output int npos, output bit nfwd);
    nfwd = fwd;
    if (fwd) begin
      if (pos + spd >= mx) begin
        npos = mx;
        nfwd = 1'b0;
      end else begin
        npos = pos + spd;
      end
    end else if (pos <= spd) begin
      npos = 0;
      nfwd = 1'b1;
    end else begin
      npos = pos - spd;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_x[k] = 0;
      m_y[k] = 0;
      m_r[k] = 1'b1;
      m_d[k] = 1'b1;
      last_exp[k] = '0;
    end
  endtask

  task automatic check_pos(input string name);
    chk({name, "_pos0"}, act_pos(0), exp_pos(0));
    chk({name, "_pos1"}, act_pos(1), exp_pos(1));
  endtask

  // One pix_ce cycle: push expectations, advance the model, compare after the edge.
  task automatic ce_cycle(input string name, input bit de, input int hc, input int vc,
                          input bit hs, input bit vs, input bit fs, input bit pz,
                          input bit use_tab, input logic [9:0] tab_exp);
    logic [9:0] e;
    int  nx, ny;
    bit  nr, nd;
    pix_ce_i = 1'b1;
    de_i = de;
    hcount_i = 11'(hc);
    vcount_i = 11'(vc);
    hsync_i = hs;
    vsync_i = vs;
    frame_start_i = fs;
    pause_i = pz;
    e = use_tab ? tab_exp : {model_rgb(0, de, hc, vc), hs, vs};
    exp0_q.push_back(e);
    exp1_q.push_back({model_rgb(1, de, hc, vc), hs, vs});
    if (fs && !pz) begin
      for (int k = 0; k < 2; k++) begin
        axis_step(m_x[k], m_r[k], p_max_x[k], p_spd[k], nx, nr);
        axis_step(m_y[k], m_d[k], p_max_y[k], p_spd[k], ny, nd);
        m_x[k] = nx;
        m_r[k] = nr;
        m_y[k] = ny;
        m_d[k] = nd;
      end
    end
    @(posedge clk_i);
    #1;
    pix_ce_i = 1'b0;
    frame_start_i = 1'b0;
    last_exp[0] = exp0_q.pop_front();
    last_exp[1] = exp1_q.pop_front();
    chk({name, "_pix0"}, 32'(act_pix(0)), 32'(last_exp[0]));
    chk({name, "_pix1"}, 32'(act_pix(1)), 32'(last_exp[1]));
    check_pos(name);
  endtask

  initial begin
    tab[0] = '{1'b1,   0,   0, 1'b0, 1'b0, {8'hE3, 2'b00}};
    tab[1] = '{1'b1,  32,   0, 1'b1, 1'b0, {8'h00, 2'b10}};
    tab[2] = '{1'b0,   0,   0, 1'b0, 1'b1, {8'h00, 2'b01}};
    tab[3] = '{1'b1,  31,  31, 1'b1, 1'b1, {8'hE3, 2'b11}};
    tab[4] = '{1'b1,  31,  32, 1'b0, 1'b0, {8'h00, 2'b00}};
    tab[5] = '{1'b1,   0,  31, 1'b0, 1'b0, {8'hE3, 2'b00}};
    tab[6] = '{1'b1, 639, 479, 1'b0, 1'b0, {8'h00, 2'b00}};
    tab[7] = '{1'b0,   5,   5, 1'b1, 1'b1, {8'h00, 2'b11}};

    rst_ni = 1'b0;
    pix_ce_i = 1'b1;
    de_i = 1'b1;
    hcount_i = '0;
    vcount_i = '0;
    hsync_i = 1'b1;
    vsync_i = 1'b1;
    frame_start_i = 1'b1;
    pause_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_pix0", 32'(act_pix(0)), 32'h0);
    chk("reset_pix1", 32'(act_pix(1)), 32'h0);
    check_pos("reset");
    pix_ce_i = 1'b0;
    frame_start_i = 1'b0;
    #2 rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      ce_cycle($sformatf("tab%0d", i), tab[i].de, tab[i].hc, tab[i].vc, tab[i].hs, tab[i].vs,
               1'b0, 1'b0, 1'b1, tab[i].exp);
    end

    // Three frames from reset
    repeat (3) ce_cycle("fs3", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("fs3_x", 32'(dut0.x_pos_q), 32'd6);
    chk("fs3_y", 32'(dut0.y_pos_q), 32'd6);
    ce_cycle("box66", 1'b1, 6, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {8'hE3, 2'b00});
    ce_cycle("bg56", 1'b1, 5, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {8'h00, 2'b00});

    // Paused frames, then release without a frame_start
    repeat (5) ce_cycle("pause", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    ce_cycle("unpause", 1'b1, 7, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("unpause_x", 32'(dut0.x_pos_q), 32'd6);

    // Clock enable low: everything holds despite busy inputs
    for (int i = 0; i < 10; i++) begin
      pix_ce_i = 1'b0;
      de_i = 1'b1;
      hcount_i = 11'($urandom_range(0, 40));
      vcount_i = 11'($urandom_range(0, 40));
      hsync_i = ~hsync_i;
      vsync_i = 1'b1;
      frame_start_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("freeze_pix0", 32'(act_pix(0)), 32'(last_exp[0]));
      chk("freeze_pix1", 32'(act_pix(1)), 32'(last_exp[1]));
      check_pos("freeze");
    end
    frame_start_i = 1'b0;

    // Frame start inside active video: pixel uses the pre-update position
    ce_cycle("midfs", 1'b1, 6, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {8'hE3, 2'b00});
    chk("midfs_x", 32'(dut0.x_pos_q), 32'd8);

    // Long run through edge and corner bounces on both instances
    for (int i = 0; i < 420; i++) begin
      ce_cycle("run", 1'b1, $urandom_range(0, 45), $urandom_range(0, 35), i[0], i[1],
               1'b1, (i % 7) == 3, 1'b0, '0);
    end
    ce_cycle("edge_in", 1'b1, m_x[0] + 31, m_y[0] + 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    ce_cycle("edge_out", 1'b1, m_x[0] + 32, m_y[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Async reset with a box pixel on the outputs
    ce_cycle("prerst", 1'b1, m_x[0], m_y[0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("prerst_box", 32'({r0, g0, b0}), 32'hE3);
    #3 rst_ni = 1'b0;
    #1;
    chk("async_rst_pix0", 32'(act_pix(0)), 32'h0);
    chk("async_rst_pix1", 32'(act_pix(1)), 32'h0);
    model_reset();
    check_pos("async_rst");
    pix_ce_i = 1'b1;
    frame_start_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_pos("rst_hold");
    pix_ce_i = 1'b0;
    frame_start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_pos("post_rst");
    ce_cycle("post_rst_box", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {8'hE3, 2'b01});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 Parameter BOX_W, default 32: sprite width in pixels; BOX_H, default 32: sprite height in lines.
REQ-004 Parameter SPEED, default 2: pixels moved per axis per frame, 1..15.
REQ-005 Parameter BOX_RGB, default 8'b111_000_11; BG_RGB, default 8'b000_000_00: colours packed {r,g,b}.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously to clk.
REQ-008 pix_ce  input  1  pixel-rate clock enable from timing stage; all pixel-path registers advance only when high.
REQ-009 hcount  input  11  active-region x coordinate, valid when de=1.
REQ-010 vcount  input  11  active-region y coordinate, valid when de=1.
REQ-011 de  input  1  display enable (active video) from timing stage.
REQ-012 hsync_in, vsync_in  input  1 each  sync from timing stage.
REQ-013 frame_start  input  1  one-pix_ce-cycle pulse at first blanking line after active video.
REQ-014 pause  input  1  high freezes sprite position and direction.
REQ-015 r  output  3, g  output  3, b  output  2  registered pixel colour.
REQ-016 hsync, vsync  output  1 each  sync delayed to align with r/g/b.

Function
REQ-017 Pixel path latency SHALL be exactly one pix_ce cycle: r/g/b/hsync/vsync at ce-cycle n+1 reflect inputs sampled at ce-cycle n.
REQ-018 When pix_ce=0, all outputs and state SHALL hold.
REQ-019 Colour SHALL be BOX_RGB when de=1 and x_pos<=hcount<x_pos+BOX_W and y_pos<=vcount<y_pos+BOX_H; BG_RGB when de=1 otherwise; 0 when de=0.
REQ-020 Sprite position x_pos (11 bits, range 0..H_ACTIVE-BOX_W) and y_pos (11 bits, range 0..V_ACTIVE-BOX_H) SHALL update only on a pix_ce cycle with frame_start=1 and pause=0.
REQ-021 Direction FSM states: DR (down-right), DL (down-left), UR (up-right), UL (up-left); reset state DR.
REQ-022 Per axis, moving positive: if pos+SPEED >= MAX then pos<=MAX and axis direction flips; else pos<=pos+SPEED.
REQ-023 Per axis, moving negative: if pos <= SPEED then pos<=0 and axis direction flips; else pos<=pos-SPEED.
REQ-024 X and Y flips evaluated independently in the same update; corner hit flips both (e.g. DR->UL).
REQ-025 Arithmetic SHALL be 12-bit internally; no wrap-around; pos never leaves its range.
REQ-026 frame_start while de=1 (protocol violation) SHALL still update; position change then visible mid-frame, no other effect.
REQ-027 pause asserted on a frame_start cycle SHALL suppress that update; deasserting pause causes no update until next frame_start.
REQ-028 Pixel-path compare SHALL use position registers only; a position update and a pixel compare in the same cycle use the pre-update position.

Reset
REQ-029 On rst=0: r=g=b=0, hsync=vsync=0, x_pos=0, y_pos=0, FSM=DR, regardless of pix_ce.
REQ-030 Reset asserted mid-frame SHALL take effect asynchronously; first outputs after release follow REQ-017 from the next pix_ce cycle.

Verification
REQ-031 Reset, then de=1, hcount=0, vcount=0, pix_ce=1 -> next cycle {r,g,b}=BOX_RGB; hcount=32 -> BG_RGB; de=0 -> 0.
REQ-032 Three frame_start pulses from reset -> x_pos=y_pos=6, FSM=DR; pixel (6,6) box colour, (5,6) background.
REQ-033 Force x_pos=607, dir right, frame_start -> x_pos=608, FSM flips to left (DL); next frame_start -> x_pos=606.
REQ-034 Set x_pos=1,y_pos=1, FSM=UL, frame_start -> x_pos=0,y_pos=0, FSM=DR (corner, both axes flip).
REQ-035 pause=1 across 5 frame_start pulses -> position and FSM unchanged; pix_ce held 0 for 10 cycles -> outputs frozen.
REQ-036 Assert rst mid-line with box pixels on output -> r/g/b/hsync/vsync go 0 without a clk edge; x_pos=y_pos=0 after release.
